// File: rtl/image_bram_loader.sv
// Fills one image BRAM from a valid/ready pixel stream, then optionally reads
// every address back and checks the readback sum against the written sum.
module image_bram_loader #(
   parameter int unsigned NUM_PIXELS = 169,
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned DATA_W     = 8,
   parameter bit          VERIFY     = 1'b1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   input  logic              S_VALID,
   input  logic [DATA_W-1:0] S_DATA,
   output logic              S_READY,
   output logic [ADDR_W-1:0] BRAM_ADDR,
   output logic [DATA_W-1:0] BRAM_DI,
   output logic              BRAM_EN,
   output logic              BRAM_WE,
   input  logic [DATA_W-1:0] BRAM_DO,
   output logic              BUSY,
   output logic              DONE,
   output logic              ERR,
   output logic [15:0]       CHECKSUM
);

   localparam int unsigned CNT_W = $clog2(NUM_PIXELS + 1);
   localparam int unsigned SUM_W = 16;
   localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_PIXELS - 1);
   localparam logic [CNT_W-1:0] TOTAL_CNT = CNT_W'(NUM_PIXELS);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_VERIFY,
      ST_DONE,
      ST_ERROR
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] pix_cnt;
   logic [CNT_W-1:0] rd_issue;
   logic             rd_pend;
   logic             rd_last;
   logic             cmp_pend;
   logic [SUM_W-1:0] rd_sum;

   // CHECKSUM doubles as the running write sum; S_READY and BUSY mirror the state.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= ST_IDLE;
         S_READY   <= 1'b0;
         BRAM_EN   <= 1'b0;
         BRAM_WE   <= 1'b0;
         BRAM_ADDR <= '0;
         BRAM_DI   <= '0;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
         ERR       <= 1'b0;
         CHECKSUM  <= '0;
         pix_cnt   <= '0;
         rd_issue  <= '0;
         rd_pend   <= 1'b0;
         rd_last   <= 1'b0;
         cmp_pend  <= 1'b0;
         rd_sum    <= '0;
      end else begin
         BRAM_EN <= 1'b0;
         BRAM_WE <= 1'b0;
         unique case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
               if (START) begin
                  state    <= ST_LOAD;
                  S_READY  <= 1'b1;
                  BUSY     <= 1'b1;
                  DONE     <= 1'b0;
                  ERR      <= 1'b0;
                  pix_cnt  <= '0;
                  CHECKSUM <= '0;
                  rd_sum   <= '0;
               end else if (state == ST_DONE) begin
                  DONE <= 1'b1;
               end
            end

            ST_LOAD: begin
               if (S_VALID && S_READY) begin
                  BRAM_EN   <= 1'b1;
                  BRAM_WE   <= 1'b1;
                  BRAM_ADDR <= ADDR_W'(pix_cnt);
                  BRAM_DI   <= S_DATA;
                  CHECKSUM  <= CHECKSUM + SUM_W'(S_DATA);
                  pix_cnt   <= pix_cnt + CNT_W'(1);
                  if (pix_cnt == LAST_IDX) begin
                     S_READY <= 1'b0;
                     if (VERIFY) begin
                        state    <= ST_VERIFY;
                        rd_issue <= '0;
                        rd_pend  <= 1'b0;
                        rd_last  <= 1'b0;
                        cmp_pend <= 1'b0;
                     end else begin
                        state <= ST_DONE;
                        BUSY  <= 1'b0;
                     end
                  end
               end
            end

            // Three-deep pipeline: issue read, capture BRAM_DO next edge, compare after last capture.
            ST_VERIFY: begin
               if (rd_issue != TOTAL_CNT) begin
                  BRAM_EN   <= 1'b1;
                  BRAM_ADDR <= ADDR_W'(rd_issue);
                  rd_issue  <= rd_issue + CNT_W'(1);
               end
               rd_pend  <= (rd_issue != TOTAL_CNT);
               rd_last  <= (rd_issue == LAST_IDX);
               cmp_pend <= rd_pend && rd_last;
               if (rd_pend) begin
                  rd_sum <= rd_sum + SUM_W'(BRAM_DO);
               end
               if (cmp_pend) begin
                  BUSY <= 1'b0;
                  if (rd_sum == CHECKSUM) begin
                     state <= ST_DONE;
                     DONE  <= 1'b1;
                  end else begin
                     state <= ST_ERROR;
                     ERR   <= 1'b1;
                  end
               end
            end

            default: begin
               state   <= ST_IDLE;
               S_READY <= 1'b0;
               BUSY    <= 1'b0;
            end
         endcase
      end
   end

endmodule
